hi_sim_sequencer: RTL
=====================

Name: hi_sim_sequencer

Overview:
Frame-level controller for the HF tag-simulation datapath. It watches the post-hysteresis receive level, detects reader pauses and end of reader frame, and waits a fixed frame delay time. It then drives the datapath's mod_type and modulation data for an ARM-armed response of N bit periods, and returns to listening. It sits between the ARM/SSP-facing logic and the simulate datapath, which it sequences.

Parameters:
CNT_W, 12, width of all cycle counters
PAUSE_MIN, 16, minimum consecutive low cycles of rx_level counted as a reader pause
EOF_CYCLES, 256, high cycles after the last pause that mark end of reader frame
FDT_CYCLES, 1172, cycles from the last pause rising edge to the first response bit; must be greater than EOF_CYCLES
BIT_CYCLES, 128, cycles per response bit period

Ports:
ck_1356meg  in  1  13.56 MHz carrier clock; all logic on its rising edge
nreset  in  1  asynchronous active-low reset
enable  in  1  sequencer enable; low forces IDLE
rx_level  in  1  post-hysteresis demodulated level (1 = carrier present, 0 = pause); already synchronous to ck_1356meg
cfg_mod_type  in  3  mod_type driven during TX (001/010/100)
tx_arm  in  1  one-cycle pulse: latch tx_len and set the response-pending flag
tx_len  in  8  response length in bit periods; 0 = no response
tx_bit  in  1  data for the current bit; sampled in the cycle tx_bit_req is high
mod_type  out  3  to datapath; 000 except in TX
mod_data  out  1  to datapath modulation input (ssp_dout role)
tx_bit_req  out  1  one-cycle pulse at the start of each bit period
frame_seen  out  1  one-cycle pulse on end-of-reader-frame detection
tx_done  out  1  one-cycle pulse after the last bit period completes
busy  out  1  high in FDT_WAIT and TX
state  out  3  debug: IDLE=0, LISTEN=1, FDT_WAIT=2, TX=3

Behaviour:
- Reset (async, nreset=0): state IDLE; all outputs 0; counters 0; pending flag clear; latched length 0.
- IDLE: enable=1 moves to LISTEN on the next cycle. If enable=0 in any state: IDLE on the next edge, mod_type=000, mod_data=0, pending kept.
- Pause detector (active in LISTEN and FDT_WAIT):
  - low_cnt increments while rx_level=0 and saturates at all-ones; it clears when rx_level=1.
  - A pause is valid when rx_level rises with low_cnt >= PAUSE_MIN. A shorter low is ignored and does not reset since_pause.
  - since_pause clears on a valid pause and otherwise increments, saturating.
  - frame_active sets on a valid pause.
- LISTEN: mod_type=000. When frame_active=1 and since_pause reaches EOF_CYCLES with rx_level=1:
  - pulse frame_seen; clear frame_active.
  - If pending=1: go to FDT_WAIT. Otherwise stay in LISTEN.
- FDT_WAIT: since_pause keeps counting.
  - A new valid pause returns to LISTEN with frame_active=1; pending is kept.
  - When since_pause = FDT_CYCLES-1: enter TX, clear pending, load bit_cnt = latched length and phase = 0.
- TX: mod_type = cfg_mod_type, sampled at TX entry and held.
  - tx_bit_req is high in each cycle with phase=0. mod_data = tx_bit registered at that cycle, so it is valid from phase=1 to the end of the period. mod_data is 0 in the first cycle of TX.
  - phase counts 0..BIT_CYCLES-1 and then wraps. bit_cnt decrements at each wrap.
  - After the wrap that takes bit_cnt to 0: pulse tx_done, mod_type=000, mod_data=0, go to LISTEN.
  - rx_level is ignored in TX.
- Arming:
  - tx_arm with tx_len != 0 latches the length and sets pending in IDLE, LISTEN or FDT_WAIT.
  - tx_arm with tx_len=0 clears pending.
  - tx_arm in TX is ignored.
  - tx_arm in the same cycle as the FDT_WAIT->TX transition is ignored; the armed length is used.
- Counters saturate and never wrap. Arithmetic is unsigned CNT_W.
- Outputs are registered. mod_type changes exactly on TX entry and exit edges.

Test Plan:
- Reset: nreset low mid-TX (bit 3 of 8) -> same cycle mod_type=000, mod_data=0, state=0, busy=0. After release with enable=1 -> LISTEN in 1 cycle.
- Basic response: arm tx_len=4, cfg_mod_type=010; apply pause rx_level=0 for 40 cycles then high -> frame_seen exactly 256 cycles after the rising edge. First tx_bit_req 1172 cycles after the rising edge; 4 requests 128 apart; tx_done 512 cycles after TX entry; mod_data tracks tx_bit pattern 1,0,1,1.
- Glitch rejection: low pulses of 15 cycles only -> no frame_seen, no TX. A 16-cycle low -> valid pause.
- Multi-pause frame: pauses 128 cycles apart, the last followed by idle -> a single frame_seen, timed from the last pause. A pause inserted at cycle 600 of FDT_WAIT -> back to LISTEN; TX timed from the new pause.
- No pending: no tx_arm -> frame_seen pulses, state stays LISTEN, mod_type stays 000. tx_arm with tx_len=0 after arming 5 -> no TX.
- enable drop during FDT_WAIT -> IDLE next cycle; pending kept; re-enable plus a new frame -> TX occurs.

Source files
------------

// File: rtl/hi_sim_sequencer.sv
// ---------------------------------------------------------------------------
// hi_sim_sequencer
//
// Frame-level controller for the HF tag-simulation datapath. It watches the
// post-hysteresis receive level for reader pauses and detects the end of a
// reader frame. If a response is armed, it waits the frame delay time after
// the last pause. It then drives mod_type and the modulation data for the
// armed number of bit periods, and returns to listening.
//
// Ports
//   ck_1356meg    in   13.56 MHz carrier clock, rising edge
//   nreset        in   asynchronous active-low reset
//   enable        in   sequencer enable; low forces IDLE
//   rx_level      in   demodulated level (1 = carrier, 0 = pause), synchronous
//   cfg_mod_type  in   mod_type to drive during TX, sampled at TX entry
//   tx_arm        in   pulse: latch tx_len and set/clear the pending response
//   tx_len        in   response length in bit periods (0 = cancel)
//   tx_bit        in   data for the bit being requested
//   mod_type      out  datapath mod_type, 000 outside TX
//   mod_data      out  datapath modulation data
//   tx_bit_req    out  pulse at the start of every bit period
//   frame_seen    out  pulse on end-of-reader-frame detection
//   tx_done       out  pulse after the last bit period
//   busy          out  high in FDT_WAIT and TX
//   state         out  debug state: IDLE=0 LISTEN=1 FDT_WAIT=2 TX=3
// ---------------------------------------------------------------------------
module hi_sim_sequencer #(
    parameter int CNT_W      = 12,
    parameter int PAUSE_MIN  = 16,
    parameter int EOF_CYCLES = 256,
    parameter int FDT_CYCLES = 1172,
    parameter int BIT_CYCLES = 128
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       enable,
    input  logic       rx_level,
    input  logic [2:0] cfg_mod_type,
    input  logic       tx_arm,
    input  logic [7:0] tx_len,
    input  logic       tx_bit,
    output logic [2:0] mod_type,
    output logic       mod_data,
    output logic       tx_bit_req,
    output logic       frame_seen,
    output logic       tx_done,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LISTEN   = 3'd1,
        ST_FDT_WAIT = 3'd2,
        ST_TX       = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PAUSE_THR = CNT_W'(PAUSE_MIN);
    // since_pause is compared one short of the target so that the registered
    // pulse/transition lands exactly EOF_CYCLES / FDT_CYCLES after the rising edge.
    localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_CYCLES - 1);
    localparam logic [CNT_W-1:0] FDT_LAST  = CNT_W'(FDT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] since_pause;
    logic             frame_active;
    logic             pending;
    logic [7:0]       len_q;
    logic [7:0]       bit_cnt;
    logic [CNT_W-1:0] phase;

    logic             detecting;
    logic             valid_pause;
    logic             eof_hit;
    logic             fdt_hit;
    logic             tx_enter;
    logic             arm_ok;
    logic [CNT_W-1:0] low_cnt_inc;
    logic [CNT_W-1:0] since_inc;

    assign state = state_q;

    // Saturating increments: the counters stick at all-ones instead of wrapping.
    assign low_cnt_inc = (low_cnt == '1) ? low_cnt : low_cnt + CNT_ONE;
    assign since_inc   = (since_pause == '1) ? since_pause : since_pause + CNT_ONE;

    // A pause only counts on the rising edge of rx_level after a long enough low.
    assign detecting   = (state_q == ST_LISTEN) || (state_q == ST_FDT_WAIT);
    assign valid_pause = detecting && rx_level && (low_cnt >= PAUSE_THR);
    assign eof_hit     = (state_q == ST_LISTEN) && frame_active && rx_level
                         && (since_pause >= EOF_LAST);
    assign fdt_hit     = (state_q == ST_FDT_WAIT) && (since_pause == FDT_LAST);
    // A new pause at the FDT deadline wins: the reader is still talking.
    assign tx_enter    = enable && fdt_hit && !valid_pause && pending;
    // Arming is locked out during TX and on the edge that starts TX, so the
    // length already latched is the one transmitted.
    assign arm_ok      = tx_arm && (state_q != ST_TX) && !tx_enter;

    // NOTE: every register here is written with non-blocking assignments so
    // that all right-hand sides see the pre-edge values, whatever the order
    // of the statements below.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            low_cnt      <= '0;
            since_pause  <= '0;
            frame_active <= 1'b0;
            pending      <= 1'b0;
            len_q        <= '0;
            bit_cnt      <= '0;
            phase        <= '0;
            mod_type     <= 3'b000;
            mod_data     <= 1'b0;
            tx_bit_req   <= 1'b0;
            frame_seen   <= 1'b0;
            tx_done      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Single-cycle pulses default low and are raised only where needed.
            frame_seen <= 1'b0;
            tx_done    <= 1'b0;
            tx_bit_req <= 1'b0;

            if (arm_ok) begin
                if (tx_len != 8'd0) begin
                    len_q   <= tx_len;
                    pending <= 1'b1;
                end else begin
                    pending <= 1'b0;
                end
            end

            if (!enable) begin
                // Pending response and latched length survive a disable.
                state_q      <= ST_IDLE;
                mod_type     <= 3'b000;
                mod_data     <= 1'b0;
                busy         <= 1'b0;
                low_cnt      <= '0;
                since_pause  <= '0;
                frame_active <= 1'b0;
                phase        <= '0;
                bit_cnt      <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_LISTEN;
                        low_cnt     <= '0;
                        since_pause <= '0;
                    end

                    ST_LISTEN, ST_FDT_WAIT: begin
                        low_cnt     <= rx_level ? '0 : low_cnt_inc;
                        // Short lows keep since_pause running.
                        since_pause <= valid_pause ? '0 : since_inc;
                        if (valid_pause) begin
                            frame_active <= 1'b1;
                        end

                        if (state_q == ST_LISTEN) begin
                            if (!valid_pause && eof_hit) begin
                                frame_seen   <= 1'b1;
                                frame_active <= 1'b0;
                                if (pending) begin
                                    state_q <= ST_FDT_WAIT;
                                    busy    <= 1'b1;
                                end
                            end
                        end else if (valid_pause) begin
                            // Reader resumed: go back and wait for a new end of frame.
                            state_q <= ST_LISTEN;
                            busy    <= 1'b0;
                        end else if (tx_enter) begin
                            state_q     <= ST_TX;
                            pending     <= 1'b0;
                            bit_cnt     <= len_q;
                            phase       <= '0;
                            tx_bit_req  <= 1'b1;
                            mod_type    <= cfg_mod_type;
                            mod_data    <= 1'b0;
                            low_cnt     <= '0;
                            since_pause <= '0;
                        end else if (fdt_hit) begin
                            // Response was cancelled while waiting.
                            state_q <= ST_LISTEN;
                            busy    <= 1'b0;
                        end
                    end

                    ST_TX: begin
                        if (tx_bit_req) begin
                            mod_data <= tx_bit;
                        end
                        if (phase == BIT_LAST) begin
                            phase   <= '0;
                            bit_cnt <= bit_cnt - 8'd1;
                            if (bit_cnt <= 8'd1) begin
                                tx_done  <= 1'b1;
                                mod_type <= 3'b000;
                                mod_data <= 1'b0;
                                busy     <= 1'b0;
                                state_q  <= ST_LISTEN;
                            end else begin
                                tx_bit_req <= 1'b1;
                            end
                        end else begin
                            phase <= phase + CNT_ONE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
